// File: rtl/painel_advertencia.sv
// -----------------------------------------------------------------------------
// painel_advertencia
// Dashboard-side driver for the seat-belt warning request. The request is
// debounced by a consecutive-sample filter; once accepted, the lamp blinks with
// a fixed half-period and the chime sounds for a fixed number of cycles. Each
// accepted alert increments a saturating episode counter.
//
// Ports
//   clk              in   1  clock, rising edge
//   rst_n            in   1  asynchronous active-low reset
//   luz_req          in   1  warning request, synchronous to clk
//   lampada          out  1  warning lamp, registered
//   buzina           out  1  chime, registered
//   estado           out  2  FSM state (0 OCIOSO, 1 FILTRO, 2 ALERTA, 3 PISCA)
//   contagem_alertas out  8  alert episodes, saturating at 255
// -----------------------------------------------------------------------------
module painel_advertencia #(
  parameter int FILTRO_CYC = 3,
  parameter int PISCA_MEIO = 4,
  parameter int BUZINA_CYC = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       luz_req,
  output logic       lampada,
  output logic       buzina,
  output logic [1:0] estado,
  output logic [7:0] contagem_alertas
);

  localparam int FW = $clog2(FILTRO_CYC) + 1;
  localparam int PW = $clog2(PISCA_MEIO) + 1;
  localparam int BW = $clog2(BUZINA_CYC) + 1;

  // Terminal values: the counter reaching these on an edge means the
  // corresponding interval ends on that edge.
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTRO_CYC - 1);
  localparam logic [PW-1:0] PISCA_LAST = PW'(PISCA_MEIO - 1);
  localparam logic [BW-1:0] BUZ_LAST   = BW'(BUZINA_CYC - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    FILTRO = 2'd1,
    ALERTA = 2'd2,
    PISCA  = 2'd3
  } estado_t;

  estado_t       estado_r, estado_nx_s;
  logic [FW-1:0] filt_r, filt_nx_s;
  logic [PW-1:0] pisca_r, pisca_nx_s;
  logic [BW-1:0] buz_cnt_r, buz_cnt_nx_s;
  logic          lamp_r, lamp_nx_s;
  logic          buz_r, buz_nx_s;
  logic [7:0]    cont_r, cont_nx_s, cont_inc_s;

  // Saturating increment of the episode counter.
  always_comb begin
    if (cont_r == 8'hFF) begin
      cont_inc_s = cont_r;
    end else begin
      cont_inc_s = cont_r + 8'd1;
    end
  end

  // Next-state and next-output logic. Defaults describe OCIOSO (everything
  // cleared), so every path back to idle clears all interval counters.
  always_comb begin
    estado_nx_s  = OCIOSO;
    filt_nx_s    = {FW{1'b0}};
    pisca_nx_s   = {PW{1'b0}};
    buz_cnt_nx_s = {BW{1'b0}};
    lamp_nx_s    = 1'b0;
    buz_nx_s     = 1'b0;
    cont_nx_s    = cont_r;

    case (estado_r)
      OCIOSO: begin
        if (luz_req) begin
          if (FILT_LAST == {FW{1'b0}}) begin
            // Single-sample filter: first high sample starts the alert.
            estado_nx_s = ALERTA;
            lamp_nx_s   = 1'b1;
            buz_nx_s    = 1'b1;
            cont_nx_s   = cont_inc_s;
          end else begin
            estado_nx_s = FILTRO;
            filt_nx_s   = FW'(1);
          end
        end else begin
          estado_nx_s = OCIOSO;
        end
      end

      FILTRO: begin
        if (!luz_req) begin
          estado_nx_s = OCIOSO;
        end else if (filt_r == FILT_LAST) begin
          // This edge carries the last required consecutive sample.
          estado_nx_s = ALERTA;
          lamp_nx_s   = 1'b1;
          buz_nx_s    = 1'b1;
          cont_nx_s   = cont_inc_s;
        end else begin
          estado_nx_s = FILTRO;
          filt_nx_s   = filt_r + FW'(1);
        end
      end

      ALERTA, PISCA: begin
        if (!luz_req) begin
          // A dropped request beats any expiry happening on the same edge.
          estado_nx_s = OCIOSO;
        end else begin
          // Blink phase runs continuously across ALERTA -> PISCA.
          if (pisca_r == PISCA_LAST) begin
            lamp_nx_s  = ~lamp_r;
            pisca_nx_s = {PW{1'b0}};
          end else begin
            lamp_nx_s  = lamp_r;
            pisca_nx_s = pisca_r + PW'(1);
          end
          if (estado_r == PISCA) begin
            estado_nx_s = PISCA;
          end else if (buz_cnt_r == BUZ_LAST) begin
            estado_nx_s = PISCA;
          end else begin
            estado_nx_s  = ALERTA;
            buz_nx_s     = 1'b1;
            buz_cnt_nx_s = buz_cnt_r + BW'(1);
          end
        end
      end

      default: begin
        estado_nx_s = OCIOSO;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_r  <= OCIOSO;
      filt_r    <= {FW{1'b0}};
      pisca_r   <= {PW{1'b0}};
      buz_cnt_r <= {BW{1'b0}};
      lamp_r    <= 1'b0;
      buz_r     <= 1'b0;
      cont_r    <= 8'd0;
    end else begin
      estado_r  <= estado_nx_s;
      filt_r    <= filt_nx_s;
      pisca_r   <= pisca_nx_s;
      buz_cnt_r <= buz_cnt_nx_s;
      lamp_r    <= lamp_nx_s;
      buz_r     <= buz_nx_s;
      cont_r    <= cont_nx_s;
    end
  end

  assign lampada          = lamp_r;
  assign buzina           = buz_r;
  assign estado           = estado_r;
  assign contagem_alertas = cont_r;

endmodule

// File: tb/tb_painel_advertencia.sv
// -----------------------------------------------------------------------------
// tb_painel_advertencia
// Directed testbench for painel_advertencia with default parameters. Inputs
// change on the falling edge, outputs are sampled on the next falling edge.
// -----------------------------------------------------------------------------
module tb_painel_advertencia;

  logic       clk;
  logic       rst_n;
  logic       luz_req;
  logic       lampada;
  logic       buzina;
  logic [1:0] estado;
  logic [7:0] contagem_alertas;

  int n_checks;
  int n_fail;

  painel_advertencia dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .luz_req          (luz_req),
    .lampada          (lampada),
    .buzina           (buzina),
    .estado           (estado),
    .contagem_alertas (contagem_alertas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       lamp;
    logic       buz;
    logic [1:0] est;
    logic [7:0] cont;
  } vec_t;

  task automatic check_out(input string tag, input logic exp_l, input logic exp_b,
                           input logic [1:0] exp_e, input logic [7:0] exp_c);
    n_checks++;
    if (lampada !== exp_l || buzina !== exp_b || estado !== exp_e ||
        contagem_alertas !== exp_c) begin
      n_fail++;
      $display("FAIL %s: got lamp=%b buz=%b est=%0d cont=%0d, required lamp=%b buz=%b est=%0d cont=%0d",
               tag, lampada, buzina, estado, contagem_alertas, exp_l, exp_b, exp_e, exp_c);
    end
  endtask

  task automatic step(input logic req);
    luz_req = req;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs j cycles after alert entry (j=0 is the entry edge).
  task automatic step_alert(input string tag, input int j, input logic [7:0] cont);
    logic l;
    logic b;
    logic [1:0] e;
    l = (((j / 4) % 2) == 0) ? 1'b1 : 1'b0;
    b = (j < 10) ? 1'b1 : 1'b0;
    e = (j < 10) ? 2'd2 : 2'd3;
    step(1'b1);
    check_out(tag, l, b, e, cont);
  endtask

  vec_t vecs[19];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    luz_req  = 1'b0;

    // Test 1 glitch, then test 3 drop at 6th ALERTA cycle and re-raise.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 2'd2, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd2};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd2};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 2'd2, 8'd2};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 2'd0, 8'd0);
    rst_n = 1'b1;
    step(1'b0);
    check_out("idle", 1'b0, 1'b0, 2'd0, 8'd0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req);
      check_out($sformatf("vec%0d", i), vecs[i].lamp, vecs[i].buz, vecs[i].est, vecs[i].cont);
    end

    // Re-raised episode continues as a steady request: j=3..39.
    for (int j = 3; j < 40; j++) begin
      step_alert($sformatf("steady_j%0d", j), j, 8'd2);
    end
    step(1'b0);
    check_out("steady_drop", 1'b0, 1'b0, 2'd0, 8'd2);

    // Test 6: drop on the edge where the chime would expire.
    step(1'b1);
    check_out("t6_f1", 1'b0, 1'b0, 2'd1, 8'd2);
    step(1'b1);
    check_out("t6_f2", 1'b0, 1'b0, 2'd1, 8'd2);
    for (int j = 0; j < 10; j++) begin
      step_alert($sformatf("t6_j%0d", j), j, 8'd3);
    end
    step(1'b0);
    check_out("t6_drop", 1'b0, 1'b0, 2'd0, 8'd3);

    // Test 4: asynchronous reset mid-cycle during ALERTA.
    step(1'b1);
    step(1'b1);
    step_alert("t4_entry", 0, 8'd4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_out("t4_async_rst", 1'b0, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1);
    check_out("t4_f1", 1'b0, 1'b0, 2'd1, 8'd0);
    step(1'b1);
    check_out("t4_f2", 1'b0, 1'b0, 2'd1, 8'd0);
    step_alert("t4_alert", 0, 8'd1);
    step(1'b0);
    check_out("t4_drop", 1'b0, 1'b0, 2'd0, 8'd1);

    // Test 5: 300 further episodes, counter saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      logic [7:0] exp_c;
      exp_c = (k + 1 >= 255) ? 8'd255 : 8'(k + 1);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      check_out($sformatf("sat_ep%0d", k), 1'b0, 1'b0, 2'd0, exp_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
